// File: rtl/jt89_wr_sched.sv
// ============================================================================
// jt89_wr_sched : two-requester write scheduler, paced PSG write issue and
//                 Game Gear stereo mux register.   Rev 1.0
// ============================================================================
`default_nettype none

module jt89_wr_sched #(
    parameter int         DEPTH   = 4,
    parameter int         WR_GAP  = 32,
    parameter logic [7:0] MUX_RST = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       a_valid,
    input  logic       a_sel,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic       b_sel,
    input  logic [7:0] b_data,
    output logic       b_ready,
    input  logic       mute,
    output logic       psg_wr_n,
    output logic [7:0] psg_din,
    output logic [7:0] mux,
    output logic       busy
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW       = $clog2(DEPTH + 1);
    localparam int              GW       = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [GW-1:0]   GAP_LOAD = (WR_GAP > 0) ? GW'(WR_GAP - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rr_q, rr_d;
    logic            wr_n_q, wr_n_d;
    logic [7:0]      din_q, din_d;
    logic [7:0]      stereo_q, stereo_d;
    logic [8:0]      mem_q [DEPTH];

    logic            w_full;
    logic            w_empty;
    logic            w_grant_a;
    logic            w_grant_b;
    logic            w_push;
    logic            w_pop;
    logic [8:0]      w_push_entry;
    logic [8:0]      w_pop_entry;

    // rr_q=1 means B is favoured on a tie; readiness looks only at the registered full flag
    assign w_full       = (count_q == FULL_CNT);
    assign w_empty      = (count_q == '0);
    assign w_grant_a    = !w_full && a_valid && (!b_valid || !rr_q);
    assign w_grant_b    = !w_full && b_valid && (!a_valid ||  rr_q);
    assign w_push       = w_grant_a || w_grant_b;
    assign w_push_entry = w_grant_a ? {a_sel, a_data} : {b_sel, b_data};
    assign w_pop        = (state_q == ST_IDLE) && !w_empty;
    assign w_pop_entry  = mem_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_d     = rr_q;
        wr_n_d   = wr_n_q;
        din_d    = din_q;
        stereo_d = stereo_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            rr_d     = w_grant_a;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + CW'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (w_pop) begin
                    if (w_pop_entry[8]) begin
                        stereo_d = w_pop_entry[7:0];
                    end else begin
                        din_d   = w_pop_entry[7:0];
                        wr_n_d  = 1'b0;
                        state_d = ST_STROBE;
                    end
                end
            end
            ST_STROBE: begin
                // release only on an enable cycle so the core sees exactly one write
                if (clk_en) begin
                    wr_n_d = 1'b1;
                    if (WR_GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (clk_en) begin
                    if (gap_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q - GW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gap_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
            wr_n_q   <= 1'b1;
            din_q    <= 8'h00;
            stereo_q <= MUX_RST;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
            wr_n_q   <= wr_n_d;
            din_q    <= din_d;
            stereo_q <= stereo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_push_entry;
        end
    end

    assign a_ready  = w_grant_a;
    assign b_ready  = w_grant_b;
    assign psg_wr_n = wr_n_q;
    assign psg_din  = din_q;
    assign mux      = mute ? 8'h00 : stereo_q;
    assign busy     = (state_q != ST_IDLE) || !w_empty;

endmodule

`default_nettype wire
